// File: rtl/pulse_pkg.sv
// Shared state, symbol type and default widths for the pulse scheduler slice.
package pulse_pkg;

  localparam int DEFAULT_TIMER_WIDTH = 16;
  localparam int DEFAULT_DUR_WIDTH   = 16;
  localparam int DEFAULT_FIFO_DEPTH  = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  typedef struct packed {
    logic                         level;
    logic [DEFAULT_DUR_WIDTH-1:0] duration;
  } symbol_t;

endpackage

// File: rtl/pulse_scheduler_if.sv
// Symbol handshake between the register/CPU side (master) and the scheduler (slave).
interface pulse_scheduler_if import pulse_pkg::*; #(
  parameter int DUR_WIDTH = DEFAULT_DUR_WIDTH
);

  logic                 sym_valid;
  logic                 sym_ready;
  logic                 sym_level;
  logic [DUR_WIDTH-1:0] sym_duration;

  modport master (
    output sym_valid,
    output sym_level,
    output sym_duration,
    input  sym_ready
  );

  modport slave (
    input  sym_valid,
    input  sym_level,
    input  sym_duration,
    output sym_ready
  );

endinterface

// File: rtl/pulse_sym_fifo.sv
// Synchronous symbol FIFO with flush; a flush beats any push or pop in the same cycle.
module pulse_sym_fifo import pulse_pkg::*; #(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic    clk,
  input  logic    sys_rst,
  input  logic    i_push,
  input  logic    i_pop,
  input  logic    i_flush,
  input  symbol_t i_data,
  output symbol_t o_head,
  output logic    o_full,
  output logic    o_empty
);

  localparam int AW = $clog2(DEPTH);

  symbol_t     r_mem [DEPTH];
  logic [AW:0] r_wrPtr;
  logic [AW:0] r_rdPtr;
  logic        w_doPush;
  logic        w_doPop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign o_head   = r_mem[r_rdPtr[AW-1:0]];
  assign w_doPush = i_push && !o_full && !i_flush;
  assign w_doPop  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + (AW+1)'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/pulse_scheduler.sv
// Turns buffered (level, duration) symbols into carrier enable/half-period for the carrier generator.
// Optional macro PULSE_SCHED_REPEAT_EN adds i_repeat_count: every symbol plays repeat_count+1 times.
module pulse_scheduler import pulse_pkg::*; #(
  parameter int TIMER_WIDTH = DEFAULT_TIMER_WIDTH,
  parameter int DUR_WIDTH   = DEFAULT_DUR_WIDTH,
  parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   sys_rst,
  input  logic                   i_start,
  input  logic                   i_stop,
  input  logic [TIMER_WIDTH-1:0] i_carrier_period,
`ifdef PULSE_SCHED_REPEAT_EN
  input  logic [7:0]             i_repeat_count,
`endif
  pulse_scheduler_if.slave       symIf,
  output logic                   o_carrier_en,
  output logic [TIMER_WIDTH-1:0] o_carrier_duration,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_underflow
);

  state_t                 r_state;
  state_t                 w_nextState;
  logic [DUR_WIDTH-1:0]   r_counter;
  logic                   r_level;
  logic [TIMER_WIDTH-1:0] r_period;
  logic                   r_underflow;
  symbol_t                w_head;
  symbol_t                w_inSym;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_startOk;
  logic                   w_symEnd;
  logic                   w_replay;
  logic                   w_finish;

  // Ready is held low while reset is asserted so every output reads 0 in reset.
  assign symIf.sym_ready = !w_full && !sys_rst;
  assign w_push          = symIf.sym_valid && symIf.sym_ready;
  assign w_inSym         = '{level: symIf.sym_level, duration: symIf.sym_duration};

  pulse_sym_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .sys_rst (sys_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_stop),
    .i_data  (w_inSym),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef PULSE_SCHED_REPEAT_EN
  logic [7:0]           r_repeatCount;
  logic [7:0]           r_repeatLeft;
  logic [DUR_WIDTH-1:0] r_curDuration;
  assign w_replay = (r_repeatLeft != 8'd0);
`else
  assign w_replay = 1'b0;
`endif

  assign w_startOk = i_start && !i_stop && (r_state == IDLE) && !w_empty;
  assign w_symEnd  = (r_state == RUN) && (r_counter == '0);
  assign w_pop     = !i_stop && ((r_state == LOAD) || (w_symEnd && !w_replay && !w_empty));
  assign w_finish  = !i_stop && w_symEnd && !w_replay && w_empty;

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (i_stop) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_startOk) w_nextState = LOAD;
        LOAD:    w_nextState = RUN;
        RUN:     if (w_finish) w_nextState = IDLE;
        default: w_nextState = IDLE;
      endcase
    end
  end

  always_comb begin
    o_carrier_en       = (r_state == RUN) && r_level;
    o_busy             = (r_state != IDLE);
    o_done             = w_finish;
    o_carrier_duration = r_period;
    o_underflow        = r_underflow;
  end

  // Loading the next symbol on the last cycle of the current one keeps marks gap-free.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_counter     <= '0;
      r_level       <= 1'b0;
      r_period      <= '0;
      r_underflow   <= 1'b0;
`ifdef PULSE_SCHED_REPEAT_EN
      r_repeatCount <= 8'd0;
      r_repeatLeft  <= 8'd0;
      r_curDuration <= '0;
`endif
    end else begin
      if (w_startOk) begin
        r_period    <= i_carrier_period;
        r_underflow <= 1'b0;
`ifdef PULSE_SCHED_REPEAT_EN
        r_repeatCount <= i_repeat_count;
`endif
      end else if (i_start && !i_stop && (r_state == IDLE) && w_empty) begin
        r_underflow <= 1'b1;
      end

      if (w_pop) begin
        r_counter <= w_head.duration;
        r_level   <= w_head.level;
`ifdef PULSE_SCHED_REPEAT_EN
        r_curDuration <= w_head.duration;
        r_repeatLeft  <= r_repeatCount;
`endif
      end else if ((r_state == RUN) && !i_stop) begin
        if (r_counter != '0) r_counter <= r_counter - DUR_WIDTH'(1);
`ifdef PULSE_SCHED_REPEAT_EN
        else if (w_replay) begin
          r_counter    <= r_curDuration;
          r_repeatLeft <= r_repeatLeft - 8'd1;
        end
`endif
      end
    end
  end

endmodule

// File: doc/pulse_scheduler.md
Name: pulse_scheduler

Overview:
- Sequences the carrier generator into a timed mark/space pulse train for the TinyQV pulse transmitter.
- Accepts (level, duration) symbols from the register/CPU side over a valid/ready handshake and buffers them in a small FIFO.
- Drives the carrier generator's enable and half-period inputs, so marks carry the carrier and spaces are silent.
- Reports busy, done and underflow status to the peripheral register block.

Parameters:
- TIMER_WIDTH, 16: width of the carrier half-period passed to the carrier generator.
- DUR_WIDTH, 16: width of a symbol duration.
- FIFO_DEPTH, 4: symbol FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock
- sys_rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse: begin transmitting
- stop  in  1  one-cycle pulse: abort immediately
- carrier_period  in  TIMER_WIDTH  carrier half-period, latched on accepted start
- sym_valid  in  1  symbol offered
- sym_ready  out  1  FIFO can accept a symbol
- sym_level  in  1  1 = mark (carrier on), 0 = space
- sym_duration  in  DUR_WIDTH  symbol length minus one, in clk cycles
- carrier_en  out  1  enable to the carrier generator
- carrier_duration  out  TIMER_WIDTH  half-period to the carrier generator
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on normal completion
- underflow  out  1  sticky; cleared by an accepted start

Behaviour:
- Reset values: every output is 0, FIFO is empty, state is IDLE, and the latched period is 0.
- Reset is asynchronous on assertion and releases synchronously to clk.
- FIFO push: occurs when sym_valid && sym_ready; sym_ready = !full.
  - A push and a pop in the same cycle are both honoured.
  - When the FIFO is full, sym_ready stays 0 even if a pop happens that cycle (no bypass).
  - Pushes are accepted in every state.
- States are IDLE, LOAD, RUN.
- IDLE:
  - carrier_en = 0.
  - start while the FIFO is non-empty: latch carrier_period, clear underflow, go to LOAD.
  - start while the FIFO is empty: ignored, and underflow is set.
- LOAD (1 cycle): pop the head symbol, counter = sym_duration, level register = sym_level, go to RUN.
- RUN:
  - carrier_en = level register.
  - The counter decrements each cycle, so a symbol with duration D occupies exactly D+1 cycles; D = 0 gives 1 cycle.
  - Counter reaches 0 with the FIFO non-empty: pop and load the next symbol in the same cycle. There is no gap between symbols.
  - Counter reaches 0 with the FIFO empty: go to IDLE, pulse done for one cycle, and carrier_en = 0 the following cycle.
- carrier_en rises on the cycle after LOAD. The first mark edge then follows the carrier generator's own latency.
- carrier_duration is driven from the latched period. It is stable for the whole transmission and never changes mid-run.
- Consecutive marks: carrier_en stays high across the boundary. The carrier is not restarted.
- stop, in any state:
  - next state IDLE, carrier_en = 0 and the FIFO flushed on the next cycle;
  - done is not asserted;
  - stop has priority over start and over any push in the same cycle (that push is discarded).
- start while busy: ignored.
- Counter arithmetic is unsigned DUR_WIDTH, with no wrap: the decrement is gated at 0.
- Reset mid-run: all state is cleared immediately and carrier_en drops asynchronously.

Optional Feature:
- Macro: PULSE_SCHED_REPEAT_EN.
- Defined:
  - adds input repeat_count [7:0], sampled on an accepted start;
  - each symbol is replayed repeat_count+1 times back-to-back, with no gap, before the FIFO is popped;
  - done is pulsed only after the last replay of the last symbol.
- Undefined: the port is absent and every symbol plays exactly once.

Decomposition:
- Shared package pulse_pkg:
  - state enum (IDLE, LOAD, RUN);
  - symbol struct {level, duration};
  - default width constants.
- Sub-module: pulse_sym_fifo, a synchronous FIFO holding the symbol struct with push, pop, full, empty and flush.
- The carrier generator is instantiated by the parent, not inside this block.

Test Plan:
- Push {1,9} and {0,4}, start, period = 3 → carrier_en high for 10 cycles then low for 5; done pulses on the 15th RUN cycle; busy then drops.
- Push {1,0} ×4 with the FIFO full → the 5th sym_valid sees sym_ready = 0; start → carrier_en high for 4 contiguous cycles.
- start with the FIFO empty → underflow = 1, busy stays 0; push {1,2} then start → underflow cleared and run proceeds.
- Push {1,100}, start, stop at RUN cycle 20 → carrier_en = 0 next cycle, FIFO empty, no done pulse.
- Assert sys_rst mid-RUN → carrier_en = 0 immediately without a clock edge; all outputs 0.
- With PULSE_SCHED_REPEAT_EN: repeat_count = 2, push {1,1} and {0,1}, start → mark, space repeated 3 times per symbol (6 cycles high, 6 cycles low); done once.
